// File: rtl/memory_arbiter.sv
// Arbiter that shares one RAM port between the icache (read-only) and the dcache (read/write).
// Optional wait-cycle performance counters are built when MEMARB_PERF_EN is defined.
module memory_arbiter #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // debug
  output logic [1:0]  owner
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0] icnt_wait,
  output logic [31:0] dcnt_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic d_req;
  logic ram_done;
  logic i_starved;

  assign d_req     = dREN | dWEN;
  assign ram_done  = (ramstate == RAM_ACCESS);
  assign i_starved = iREN && (starve_q == STARVE_LIMIT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_d = DGNT;
          // Count dcache wins only while the icache is actually waiting.
          if (iREN) begin
            starve_d = (starve_q == STARVE_LIMIT) ? starve_q : starve_q + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
        end else if (iREN) begin
          state_d  = IGNT;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~ram_done;
        iload   = ramload;
        // Return to IDLE after completion so a held request is not replayed.
        if (ram_done || !iREN) begin
          state_d = IDLE;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ram_done;
        dload    = ramload;
        if (ram_done || !d_req) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign owner = state_q;

`ifdef MEMARB_PERF_EN
  logic [31:0] icnt_q, dcnt_q;

  // Stall counters: one tick per cycle a requester is asking and being held off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (iREN && iwait) begin
        icnt_q <= icnt_q + 32'd1;
      end
      if (d_req && dwait) begin
        dcnt_q <= dcnt_q + 32'd1;
      end
    end
  end

  assign icnt_wait = icnt_q;
  assign dcnt_wait = dcnt_q;
`endif

endmodule
